// File: rtl/abs_if.sv
// Handshake bundle for the abs unit: operand in, magnitude/flags out, sticky overflow status.
interface abs_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_neg;
    logic             out_ovf;
    logic             ovf_sticky;
    logic             ovf_clr;

    modport master (
        output in_valid, in_data, out_ready, ovf_clr,
        input  in_ready, out_valid, out_data, out_neg, out_ovf, ovf_sticky
    );

    modport slave (
        input  in_valid, in_data, out_ready, ovf_clr,
        output in_ready, out_valid, out_data, out_neg, out_ovf, ovf_sticky
    );
endinterface

// File: rtl/abs.sv
// Two's-complement absolute value with a one-entry registered output and sticky overflow flag.
// Build option: define ABS_SATURATE_EN to clamp the most-negative operand to the largest positive value.
module abs #(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst,
    abs_if.slave  bus
);
    localparam logic signed [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic signed [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

    function automatic logic signed [WIDTH-1:0] negate(input logic signed [WIDTH-1:0] x);
        return (~x) + ONE;
    endfunction

    // Negating MIN_NEG has no representable result; either clamp or let it wrap to itself.
    function automatic logic signed [WIDTH-1:0] saturate_min(input logic signed [WIDTH-1:0] x);
`ifdef ABS_SATURATE_EN
        return (x == MIN_NEG) ? MAX_POS : x;
`else
        return x;
`endif
    endfunction

    logic signed [WIDTH-1:0] operand_p0;
    logic signed [WIDTH-1:0] mag_p0;
    logic                    neg_p0;
    logic                    ovf_p0;
    logic                    accept_p0;
    logic                    ready_p0;

    logic signed [WIDTH-1:0] data_p1;
    logic                    neg_p1;
    logic                    ovf_p1;
    logic                    vld_p1;
    logic                    sticky;

    // ---- stage p0: operand decode and magnitude ----
    assign operand_p0 = $signed(bus.in_data);
    assign neg_p0     = operand_p0[WIDTH-1];
    assign ovf_p0     = (operand_p0 == MIN_NEG);
    assign ready_p0   = !vld_p1 || bus.out_ready;
    assign accept_p0  = bus.in_valid && ready_p0;

    always_comb begin
        mag_p0 = operand_p0;
        if (ovf_p0)
            mag_p0 = saturate_min(operand_p0);
        else if (neg_p0)
            mag_p0 = negate(operand_p0);
    end

    // ---- stage p1: output register, reloaded on acceptance, emptied on drain ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            neg_p1  <= 1'b0;
            ovf_p1  <= 1'b0;
        end else if (accept_p0) begin
            vld_p1  <= 1'b1;
            data_p1 <= mag_p0;
            neg_p1  <= neg_p0;
            ovf_p1  <= ovf_p0;
        end else if (bus.out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    // A new overflow acceptance beats a simultaneous clear so no event is lost.
    always_ff @(posedge clk) begin
        if (rst)
            sticky <= 1'b0;
        else if (accept_p0 && ovf_p0)
            sticky <= 1'b1;
        else if (bus.ovf_clr)
            sticky <= 1'b0;
    end

    assign bus.in_ready   = ready_p0;
    assign bus.out_valid  = vld_p1;
    assign bus.out_data   = data_p1;
    assign bus.out_neg    = neg_p1;
    assign bus.out_ovf    = ovf_p1;
    assign bus.ovf_sticky = sticky;
endmodule

// File: tb/tb_abs.sv
// Directed self-checking bench for abs; expectations follow the ABS_SATURATE_EN build setting.
module tb_abs;
    localparam int WIDTH = 32;

`ifdef ABS_SATURATE_EN
    localparam logic [WIDTH-1:0] MIN_RESULT = 32'h7FFF_FFFF;
`else
    localparam logic [WIDTH-1:0] MIN_RESULT = 32'h8000_0000;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    abs_if #(.WIDTH(WIDTH)) bus ();
    abs #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0; bus.ovf_clr = 1'b0;
        step(); step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", bus.out_data); end
        n_cmp++; if (bus.out_neg !== 1'b0 || bus.out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got neg=%b ovf=%b want 0/0", bus.out_neg, bus.out_ovf); end
        n_cmp++; if (bus.ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_sticky: got %b want 0", bus.ovf_sticky); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.in_ready); end
        rst = 1'b0;
        step();
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_positive();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 32'h0000_2000;
        step();
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0000_2000 || bus.out_neg !== 1'b0) begin n_fail++; $display("FAIL pos_a: got v=%b d=%h n=%b want 1/00002000/0", bus.out_valid, bus.out_data, bus.out_neg); end
        bus.in_data = 32'h0021_A800;
        step();
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0021_A800 || bus.out_neg !== 1'b0) begin n_fail++; $display("FAIL pos_b: got v=%b d=%h n=%b want 1/0021a800/0", bus.out_valid, bus.out_data, bus.out_neg); end
        bus.in_valid = 1'b0;
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_negative();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 32'hFFE7_AA8F;
        step();
        n_cmp++; if (bus.out_data !== 32'h0018_5571 || bus.out_neg !== 1'b1 || bus.out_ovf !== 1'b0) begin n_fail++; $display("FAIL neg_a: got d=%h n=%b o=%b want 00185571/1/0", bus.out_data, bus.out_neg, bus.out_ovf); end
        bus.in_data = 32'hFFFF_FFFF;
        step();
        n_cmp++; if (bus.out_data !== 32'h0000_0001 || bus.out_neg !== 1'b1) begin n_fail++; $display("FAIL neg_one: got d=%h n=%b want 00000001/1", bus.out_data, bus.out_neg); end
        bus.in_data = 32'h0000_0000;
        step();
        n_cmp++; if (bus.out_data !== 32'h0 || bus.out_neg !== 1'b0 || bus.out_ovf !== 1'b0) begin n_fail++; $display("FAIL zero: got d=%h n=%b o=%b want 0/0/0", bus.out_data, bus.out_neg, bus.out_ovf); end
        bus.in_valid = 1'b0;
        step();
    endtask

    task automatic test_overflow();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 32'h8000_0000;
        step();
        n_cmp++; if (bus.out_data !== MIN_RESULT) begin n_fail++; $display("FAIL ovf_data: got %h want %h", bus.out_data, MIN_RESULT); end
        n_cmp++; if (bus.out_ovf !== 1'b1 || bus.out_neg !== 1'b1) begin n_fail++; $display("FAIL ovf_flags: got o=%b n=%b want 1/1", bus.out_ovf, bus.out_neg); end
        n_cmp++; if (bus.ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky_set: got %b want 1", bus.ovf_sticky); end
        bus.in_data = 32'h0000_0003;
        step();
        n_cmp++; if (bus.out_ovf !== 1'b0 || bus.ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL sticky_hold: got o=%b s=%b want 0/1", bus.out_ovf, bus.ovf_sticky); end
        bus.in_valid = 1'b0; bus.ovf_clr = 1'b1;
        step();
        n_cmp++; if (bus.ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL sticky_clr: got %b want 0", bus.ovf_sticky); end
        bus.in_valid = 1'b1; bus.in_data = 32'h8000_0000;
        step();
        n_cmp++; if (bus.ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL set_beats_clr: got %b want 1", bus.ovf_sticky); end
        bus.in_valid = 1'b0;
        step();
        n_cmp++; if (bus.ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL sticky_clr2: got %b want 0", bus.ovf_sticky); end
        bus.ovf_clr = 1'b0;
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 32'h0000_0005;
        step();
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h5) begin n_fail++; $display("FAIL bp_load: got v=%b d=%h want 1/00000005", bus.out_valid, bus.out_data); end
        bus.in_data = 32'hFFFF_FFF9;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b want 0", bus.in_ready); end
        step();
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h5 || bus.out_neg !== 1'b0) begin n_fail++; $display("FAIL bp_hold: got v=%b d=%h n=%b want 1/00000005/0", bus.out_valid, bus.out_data, bus.out_neg); end
        bus.out_ready = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); end
        step();
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h7 || bus.out_neg !== 1'b1) begin n_fail++; $display("FAIL bp_replace: got v=%b d=%h n=%b want 1/00000007/1", bus.out_valid, bus.out_data, bus.out_neg); end
        bus.in_valid = 1'b0;
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_streaming();
        logic [WIDTH-1:0] words [8] = '{32'h0000_0001, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h8000_0001,
                                        32'h0000_0010, 32'hFFFF_FFF0, 32'h1234_5678, 32'hEDCB_A988};
        logic [WIDTH-1:0] mags  [8] = '{32'h0000_0001, 32'h0000_0002, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                                        32'h0000_0010, 32'h0000_0010, 32'h1234_5678, 32'h1234_5678};
        logic             negs  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_data = words[i];
            step();
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== mags[i] || bus.out_neg !== negs[i]) begin
                n_fail++;
                $display("FAIL stream[%0d]: got v=%b d=%h n=%b want 1/%h/%b", i, bus.out_valid, bus.out_data, bus.out_neg, mags[i], negs[i]);
            end
        end
        bus.in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 32'h8000_0000;
        step();
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL mid_preload: got v=%b s=%b want 1/1", bus.out_valid, bus.ovf_sticky); end
        rst = 1'b1;
        bus.in_data = 32'h0000_0009;
        step();
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.ovf_sticky !== 1'b0 || bus.out_ovf !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got v=%b d=%h s=%b o=%b want 0/0/0/0", bus.out_valid, bus.out_data, bus.ovf_sticky, bus.out_ovf); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: got %b want 1", bus.in_ready); end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_positive();
        test_negative();
        test_overflow();
        test_backpressure();
        test_streaming();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/abs.md
# abs

Two's-complement absolute-value unit for the datapath: takes a signed WIDTH-bit word and returns its magnitude on a registered, valid/ready-handshaked output. It sits between fixed-point arithmetic stages wherever a non-negative magnitude is needed. It also flags negative inputs and the most-negative-value overflow case, with a sticky overflow status bit.

## Interface
- WIDTH, 32, data width in bits (≥2).
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  unit can accept a word this cycle.
- in_data  input  WIDTH  signed two's-complement operand.
- out_valid  output  1  result register holds a valid word.
- out_ready  input  1  downstream accepts the result this cycle.
- out_data  output  WIDTH  magnitude of the accepted operand.
- out_neg  output  1  accepted operand was negative (MSB set).
- out_ovf  output  1  accepted operand was the most-negative value (1 followed by zeros).
- ovf_sticky  output  1  set by any accepted overflow operand; cleared by rst or ovf_clr.
- ovf_clr  input  1  synchronous clear of ovf_sticky.

## Operation
- Accept when in_valid && in_ready; in_ready = !out_valid || out_ready (one-entry output register, full throughput).
- Non-negative operand (MSB = 0): out_data = in_data unchanged, out_neg = 0.
- Negative operand: out_data = (~in_data) + 1, truncated to WIDTH; out_neg = 1.
- Most-negative operand: out_ovf = 1, out_neg = 1; out_data per Configuration.
- Zero: out_data = 0, out_neg = 0, out_ovf = 0.
- out_data, out_neg, out_ovf hold stable while out_valid && !out_ready.
- ovf_sticky sets on the cycle an overflow operand is accepted; if ovf_clr and a new overflow acceptance coincide, set wins.
- No arithmetic on bits beyond WIDTH; no rounding.

## Timing
- Latency: 1 cycle; an operand accepted at edge N is on out_data with out_valid = 1 after edge N.
- Throughput: one word per cycle when out_ready held high.
- Output drops out_valid after a handshake unless a new word is accepted on the same edge.
- Back-to-back: simultaneous output handshake and input acceptance replaces the result register in one cycle, no bubble.
- Reset: on rising edge with rst = 1, out_valid = 0, out_data = 0, out_neg = 0, out_ovf = 0, ovf_sticky = 0; in_ready reads 1 during and after reset. Reset mid-stream discards the held result.
- in_ready combinationally depends on out_ready and out_valid only; no combinational path from in_data to outputs.

## Configuration
- ABS_SATURATE_EN defined: most-negative operand yields out_data = 0 followed by all ones (0x7FFFFFFF at WIDTH 32), the largest positive value.
- ABS_SATURATE_EN undefined: most-negative operand wraps, out_data = operand unchanged (0x80000000 at WIDTH 32).
- out_ovf and ovf_sticky behave identically in both builds.

## Test plan
- Positive pass-through: in_data 0x00002000, then 0x0021A800, out_ready = 1 -> out_data 0x00002000, then 0x0021A800, out_neg = 0, one cycle after each acceptance.
- Negative: in_data 0xFFE7AA8F -> out_data 0x00185571, out_neg = 1, out_ovf = 0; also 0xFFFFFFFF -> 0x00000001.
- Overflow: in_data 0x80000000 -> out_ovf = 1, ovf_sticky = 1, out_data 0x7FFFFFFF with ABS_SATURATE_EN, 0x80000000 without; ovf_clr pulse -> ovf_sticky = 0.
- Backpressure: out_ready = 0 with result 0x00000005 held, drive new in_valid -> in_ready = 0, out_data stays 0x00000005; raise out_ready -> next word loads same edge.
- Streaming: 8 consecutive words with out_ready = 1 -> 8 results on consecutive cycles in order, no bubbles.
- Reset mid-stream: assert rst while out_valid = 1 -> next edge out_valid = 0, out_data = 0, ovf_sticky = 0.
